// File: rtl/pi_mul_sequencer_if.sv
// Multiplier handshake bus between the PI sequencer (master) and the shift-add multiplier (slave).
interface pi_mul_sequencer_if #(
  parameter int N = 4
);
  logic                  MUL_Start_STRB_o;
  logic                  MUL_Done_STRB_i;
  logic signed [N-1:0]   mul_a_o;
  logic signed [N-1:0]   mul_b_o;
  logic signed [2*N-1:0] mul_out_i;

  modport master (
    output MUL_Start_STRB_o, mul_a_o, mul_b_o,
    input  MUL_Done_STRB_i, mul_out_i
  );

  modport slave (
    input  MUL_Start_STRB_o, mul_a_o, mul_b_o,
    output MUL_Done_STRB_i, mul_out_i
  );
endinterface

// File: rtl/pi_mul_sequencer.sv
// Fan-control PI update engine: error, saturating integrator, two sequenced multiplies
// on an external multiplier, then sum/scale/saturate into a held N-bit command.
module pi_mul_sequencer #(
  parameter int N         = 4,
  parameter int ACC_W     = 8,
  parameter int I_SHIFT   = 2,
  parameter int OUT_SHIFT = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                CTRL_Start_STRB_i,
  input  logic signed [N-1:0] setpoint_i,
  input  logic signed [N-1:0] measure_i,
  input  logic signed [N-1:0] kp_i,
  input  logic signed [N-1:0] ki_i,
  input  logic                integ_clr_i,
  pi_mul_sequencer_if.master  mul,
  output logic signed [N-1:0] ctrl_o,
  output logic                CTRL_Done_STRB_o,
  output logic                busy_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL_P, S_WAIT_P, S_MUL_I, S_WAIT_I, S_SUM, S_DONE
  } state_e;

  // N-bit saturation bounds, sign-extended to each source width
  localparam logic signed [N-1:0]     NMAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]     NMIN     = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_NMAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_NMIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [2*N:0]     U_NMAX   = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0]     U_NMIN   = {{(N+2){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_e state_q, state_d;
  logic signed [N-1:0]     sp_q, meas_q, kp_q, ki_q, a_q, b_q, ctrl_q;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [2*N-1:0]   p_q, q_q;
  logic                    mul_start, done_strb;

  logic signed [N:0]       e_w;
  logic signed [N-1:0]     e_sat;
  logic signed [ACC_W:0]   i_w;
  logic signed [ACC_W-1:0] i_sat, i_sh;
  logic signed [N-1:0]     ib_sat;
  logic signed [2*N:0]     u_w, u_sh;
  logic signed [N-1:0]     ctrl_sat;

  // One extra bit is enough to detect overflow on a single add/sub
  assign e_w   = $signed({sp_q[N-1], sp_q}) - $signed({meas_q[N-1], meas_q});
  assign e_sat = (e_w[N] != e_w[N-1]) ? (e_w[N] ? NMIN : NMAX) : e_w[N-1:0];

  assign i_w   = $signed({integ_q[ACC_W-1], integ_q})
               + $signed({{(ACC_W+1-N){e_sat[N-1]}}, e_sat});
  assign i_sat = (i_w[ACC_W] != i_w[ACC_W-1]) ? (i_w[ACC_W] ? ACC_MIN : ACC_MAX)
                                              : i_w[ACC_W-1:0];

  assign i_sh   = integ_q >>> I_SHIFT;
  assign ib_sat = (i_sh > ACC_NMAX) ? NMAX : (i_sh < ACC_NMIN) ? NMIN : i_sh[N-1:0];

  assign u_w      = $signed({p_q[2*N-1], p_q}) + $signed({q_q[2*N-1], q_q});
  assign u_sh     = u_w >>> OUT_SHIFT;
  assign ctrl_sat = (u_sh > U_NMAX) ? NMAX : (u_sh < U_NMIN) ? NMIN : u_sh[N-1:0];

  // Clear has priority over the ERR update and acts in every state
  always_comb begin
    integ_d = integ_q;
    if (integ_clr_i)            integ_d = '0;
    else if (state_q == S_ERR)  integ_d = i_sat;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    done_strb = 1'b0;
    case (state_q)
      S_IDLE:   if (CTRL_Start_STRB_i) state_d = S_ERR;
      S_ERR:    state_d = S_MUL_P;
      S_MUL_P:  begin mul_start = 1'b1; state_d = S_WAIT_P; end
      S_WAIT_P: if (mul.MUL_Done_STRB_i) state_d = S_MUL_I;
      S_MUL_I:  begin mul_start = 1'b1; state_d = S_WAIT_I; end
      S_WAIT_I: if (mul.MUL_Done_STRB_i) state_d = S_SUM;
      S_SUM:    state_d = S_DONE;
      S_DONE:   begin done_strb = 1'b1; state_d = S_IDLE; end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Operands are staged one state early so they are stable while the start strobe is high
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sp_q <= '0; meas_q <= '0; kp_q <= '0; ki_q <= '0;
      a_q  <= '0; b_q    <= '0; p_q  <= '0; q_q  <= '0;
      ctrl_q  <= '0;
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
      case (state_q)
        S_IDLE: if (CTRL_Start_STRB_i) begin
          sp_q <= setpoint_i; meas_q <= measure_i; kp_q <= kp_i; ki_q <= ki_i;
        end
        S_ERR: begin
          a_q <= kp_q;
          b_q <= e_sat;
        end
        S_WAIT_P: if (mul.MUL_Done_STRB_i) begin
          p_q <= mul.mul_out_i;
          a_q <= ki_q;
          b_q <= ib_sat;
        end
        S_WAIT_I: if (mul.MUL_Done_STRB_i) q_q <= mul.mul_out_i;
        S_SUM:    ctrl_q <= ctrl_sat;
        default: ;
      endcase
    end
  end

  assign mul.MUL_Start_STRB_o = mul_start;
  assign mul.mul_a_o          = a_q;
  assign mul.mul_b_o          = b_q;
  assign ctrl_o               = ctrl_q;
  assign CTRL_Done_STRB_o     = done_strb;
  assign busy_o               = (state_q != S_IDLE);
endmodule

// File: tb/tb_pi_mul_sequencer.sv
// Directed bench for pi_mul_sequencer: behavioural multiplier stub, arithmetic PI model,
// per-cycle compare of operands, command, hold and latency.
module tb_pi_mul_sequencer;
  localparam int N = 4;

  logic clk_i = 1'b0, rstn_i = 1'b1;
  logic start = 1'b0, clr = 1'b0;
  logic signed [N-1:0] sp = '0, meas = '0, kp = '0, ki = '0;
  logic signed [N-1:0] ctrl_o;
  logic done_o, busy_o;

  pi_mul_sequencer_if #(.N(N)) mif ();

  pi_mul_sequencer #(.N(N), .ACC_W(8), .I_SHIFT(2), .OUT_SHIFT(2)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .CTRL_Start_STRB_i (start),
    .setpoint_i        (sp),
    .measure_i         (meas),
    .kp_i              (kp),
    .ki_i              (ki),
    .integ_clr_i       (clr),
    .mul               (mif),
    .ctrl_o            (ctrl_o),
    .CTRL_Done_STRB_o  (done_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Multiplier stub: product registered at start, done pulses lat cycles later.
  // Counter is deliberately not reset so an aborted multiply still delivers a late done.
  int cnt = 0, lat_p = 1, lat_i = 1;
  logic ph = 1'b0, inj = 1'b0;
  logic signed [2*N-1:0] prod = '0;
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ph <= 1'b0;
    else if (mif.MUL_Start_STRB_o) begin
      cnt  <= ph ? lat_i : lat_p;
      ph   <= ~ph;
      prod <= 8'(int'(mif.mul_a_o) * int'(mif.mul_b_o));
    end else if (cnt > 0) cnt <= cnt - 1;
  end
  assign mif.MUL_Done_STRB_i = (cnt == 1) | inj;
  assign mif.mul_out_i       = prod;

  // Expectations
  typedef struct { int a; int b; } op_t;
  op_t opq[$];
  int  ctlq[$];
  int  exp_hold = 0;
  int  done_cnt = 0, done_cyc = 0;
  int  mI = 0;

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (mif.MUL_Start_STRB_o) begin
        if (opq.size() == 0) bad("spurious_mul_start");
        else begin
          op_t op;
          op = opq.pop_front();
          chk("mul_a", int'(mif.mul_a_o), op.a);
          chk("mul_b", int'(mif.mul_b_o), op.b);
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (ctlq.size() == 0) bad("spurious_done");
        else begin
          exp_hold = ctlq.pop_front();
          chk("ctrl_o", int'(ctrl_o), exp_hold);
        end
      end else chk("ctrl_hold", int'(ctrl_o), exp_hold);
    end
  end

  function automatic int clamp(input int x, input int lo, input int hi);
    return (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  // Model one update from the arithmetic rules, then drive it and wait for DONE
  task automatic upd(input int s, input int m, input int p, input int i,
                     input int lp, input int li, input bit clr_err, input bit abuse,
                     output int res);
    int e, b2, t0, dc0, c;
    e   = clamp(s - m, -8, 7);
    mI  = clr_err ? 0 : clamp(mI + e, -128, 127);
    b2  = clamp(mI >>> 2, -8, 7);
    res = clamp((p * e + i * b2) >>> 2, -8, 7);
    opq.push_back('{p, e});
    opq.push_back('{i, b2});
    ctlq.push_back(res);
    lat_p = lp; lat_i = li;
    if (abuse) begin
      inj = 1'b1;
      @(posedge clk_i); #1;
      inj = 1'b0;
    end
    dc0 = done_cnt;
    sp = 4'(s); meas = 4'(m); kp = 4'(p); ki = 4'(i);
    start = 1'b1; clr = clr_err;
    t0 = cyc;
    c = 0;
    while (done_cnt == dc0 && c < 80) begin
      @(posedge clk_i); #1;
      c++;
      if (done_cnt != dc0) break;
      if (c == 1) chk("busy_run", int'(busy_o), 1);
      clr   = (c == 1) ? clr_err : 1'b0;
      start = abuse && (c == 3 || c == 5 || c == 5 + lp + li);
      inj   = abuse && (c == 2 || c == 4 + lp + li);
    end
    start = 1'b0; inj = 1'b0; clr = 1'b0;
    if (done_cnt == dc0) bad("timeout");
    else begin
      chk("latency", done_cyc - t0 + 1, 6 + lp + li);
      chk("busy_idle", int'(busy_o), 0);
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk_i); #1;
    clr = 1'b0;
    mI = 0;
  endtask

  int r;
  initial begin
    #1 rstn_i = 1'b0;
    #1;
    chk("rst_busy",  int'(busy_o), 0);
    chk("rst_ctrl",  int'(ctrl_o), 0);
    chk("rst_done",  int'(done_o), 0);
    chk("rst_start", int'(mif.MUL_Start_STRB_o), 0);
    chk("rst_a",     int'(mif.mul_a_o), 0);
    chk("rst_b",     int'(mif.mul_b_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic: e=2, I=2, ops (2,2),(1,0), ctrl=1
    upd(3, 1, 2, 1, 2, 3, 1'b0, 1'b0, r);
    chk("basic_model", r, 1);
    chk("basic_ctrl", int'(ctrl_o), 1);

    clr_pulse();
    upd(7, -8, 7, 7, 4, 1, 1'b0, 1'b0, r);
    chk("possat_model", r, 7);
    chk("possat_ctrl", int'(ctrl_o), 7);

    clr_pulse();
    upd(-8, 7, 7, 7, 1, 5, 1'b0, 1'b0, r);
    chk("negsat_model", r, -8);
    chk("negsat_ctrl", int'(ctrl_o), -8);

    // Protocol abuse around a basic update
    clr_pulse();
    upd(3, 1, 2, 1, 2, 2, 1'b0, 1'b1, r);
    chk("abuse_ctrl", int'(ctrl_o), 1);

    // Windup: integrator climbs by 7 per update, pins at 127
    clr_pulse();
    for (int n = 1; n <= 20; n++) begin
      upd(7, 0, 0, 7, 1, 1, 1'b0, 1'b0, r);
      if (n == 18) chk("windup_I18", mI, 126);
      if (n == 19) chk("windup_I19", mI, 127);
    end
    chk("windup_I20", mI, 127);
    chk("windup_ctrl", int'(ctrl_o), 7);

    clr_pulse();
    upd(7, 0, 0, 7, 1, 1, 1'b0, 1'b0, r);
    chk("postclr_model", r, 1);
    chk("postclr_ctrl", int'(ctrl_o), 1);

    // Clear held through ERR wins over the accumulate
    upd(7, 0, 0, 7, 1, 1, 1'b1, 1'b0, r);
    chk("clr_err_ctrl", int'(ctrl_o), 0);

    // Async reset while waiting on the first multiply
    lat_p = 10; lat_i = 10;
    opq.push_back('{2, 2});
    sp = 4'sd3; meas = 4'sd1; kp = 4'sd2; ki = 4'sd1;
    start = 1'b1;
    @(posedge clk_i); #1;
    start = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    opq.delete(); ctlq.delete();
    exp_hold = 0; mI = 0;
    rstn_i = 1'b0;
    #1;
    chk("arst_busy",  int'(busy_o), 0);
    chk("arst_ctrl",  int'(ctrl_o), 0);
    chk("arst_start", int'(mif.MUL_Start_STRB_o), 0);
    chk("arst_a",     int'(mif.mul_a_o), 0);
    chk("arst_b",     int'(mif.mul_b_o), 0);
    chk("arst_done",  int'(done_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (25) @(posedge clk_i);
    #1;
    chk("late_done_busy", int'(busy_o), 0);
    upd(3, 1, 2, 1, 3, 2, 1'b0, 1'b0, r);
    chk("post_rst_ctrl", int'(ctrl_o), 1);

    chk("opq_empty", opq.size(), 0);
    chk("ctlq_empty", ctlq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
